// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: bundles the datapath-facing signals of the
// pipeline control/hazard unit.
//   master : datapath side (drives instruction fields and stage specifiers)
//   slave  : controller side (drives stage control, forwarding and hazard lines)
interface pipeline_controller_if #(
  parameter int REG_W = 5
);
  // Instruction fields and branch compare result in D
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             eq_d;
  // Register specifiers carried by the datapath pipeline registers
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] rs_x;
  logic [REG_W-1:0] rt_x;
  logic [REG_W-1:0] rt_m;
  logic [REG_W-1:0] write_reg_x;
  logic [REG_W-1:0] write_reg_m;
  logic [REG_W-1:0] write_reg_w;
  // Stage control bits
  logic             mem_to_reg_w;
  logic             dmem_write_m;
  logic             reg_write_w;
  logic             alu_src_x;
  logic             reg_dest_x;
  logic [2:0]       alu_ctrl_x;
  logic [1:0]       result_src_x;
  // Multiply/divide unit control
  logic             md_start_x;
  logic             md_div_x;
  logic             md_busy;
  // Program-counter control
  logic             pc_src_d;
  logic             jump_d;
  // Hazard control
  logic             stall_f;
  logic             stall_d;
  logic             flush_x;
  logic             flush_d;
  logic [1:0]       fwd_a_x;
  logic [1:0]       fwd_b_x;
  logic             fwd_a_d;
  logic             fwd_b_d;
  logic             forward_w_m;

  modport master (
    output op, funct, eq_d, rs_d, rt_d, rs_x, rt_x, rt_m,
           write_reg_x, write_reg_m, write_reg_w,
    input  mem_to_reg_w, dmem_write_m, reg_write_w, alu_src_x, reg_dest_x,
           alu_ctrl_x, result_src_x, md_start_x, md_div_x, md_busy,
           pc_src_d, jump_d, stall_f, stall_d, flush_x, flush_d,
           fwd_a_x, fwd_b_x, fwd_a_d, fwd_b_d, forward_w_m
  );

  modport slave (
    input  op, funct, eq_d, rs_d, rt_d, rs_x, rt_x, rt_m,
           write_reg_x, write_reg_m, write_reg_w,
    output mem_to_reg_w, dmem_write_m, reg_write_w, alu_src_x, reg_dest_x,
           alu_ctrl_x, result_src_x, md_start_x, md_div_x, md_busy,
           pc_src_d, jump_d, stall_f, stall_d, flush_x, flush_d,
           fwd_a_x, fwd_b_x, fwd_a_d, fwd_b_d, forward_w_m
  );
endinterface

// File: rtl/pipeline_controller.sv
// pipeline_controller: control decode and hazard unit for a 5-stage MIPS
// pipeline with a multi-cycle multiply/divide unit.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : pipeline_controller_if.slave -- instruction fields and stage
//           specifiers in; stage control, forwarding selects, stalls and
//           flushes out.
module pipeline_controller #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4,
  parameter bit FWD_EN     = 1'b1,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_controller_if.slave bus
);
  localparam int              CNT_W   = $clog2(MD_LATENCY + 32'd1);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  // A register match that can cause a hazard; $0 is hardwired and never one
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return (src != {REG_W{1'b0}}) && (src == dst);
  endfunction

  // D-stage decode
  logic       reg_write_s, mem_to_reg_s, dmem_write_s, alu_src_s, reg_dest_s;
  logic       branch_s, jump_s, md_s, md_div_s, mf_s;
  logic [2:0] alu_ctrl_s;
  logic [1:0] result_src_s;
  // D-X register
  logic       reg_write_x_r, mem_to_reg_x_r, dmem_write_x_r, alu_src_x_r, reg_dest_x_r;
  logic       md_x_r, md_div_x_r;
  logic [2:0] alu_ctrl_x_r;
  logic [1:0] result_src_x_r;
  // X-M and M-W registers
  logic       reg_write_m_r, mem_to_reg_m_r, dmem_write_m_r;
  logic       reg_write_w_r, mem_to_reg_w_r;
  // Busy counter and hazard results
  logic [CNT_W-1:0] md_cnt_r;
  logic             busy_s, stall_s, pc_src_s, flush_d_s;
  logic             lu_stall_s, br_stall_s, md_stall_s, nf_stall_s;
  logic [1:0]       fwd_a_x_s, fwd_b_x_s;
  logic             fwd_a_d_s, fwd_b_d_s, fwd_w_m_s;

  // Main decoder: op/funct to D-stage control bits
  always_comb begin
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    dmem_write_s = 1'b0;
    alu_src_s    = 1'b0;
    reg_dest_s   = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    md_s         = 1'b0;
    md_div_s     = 1'b0;
    mf_s         = 1'b0;
    alu_ctrl_s   = 3'b000;
    result_src_s = 2'b00;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h20: begin reg_write_s = 1'b1; reg_dest_s = 1'b1; alu_ctrl_s = 3'b010; end
          6'h22: begin reg_write_s = 1'b1; reg_dest_s = 1'b1; alu_ctrl_s = 3'b110; end
          6'h24: begin reg_write_s = 1'b1; reg_dest_s = 1'b1; alu_ctrl_s = 3'b000; end
          6'h25: begin reg_write_s = 1'b1; reg_dest_s = 1'b1; alu_ctrl_s = 3'b001; end
          6'h2A: begin reg_write_s = 1'b1; reg_dest_s = 1'b1; alu_ctrl_s = 3'b111; end
          6'h18: md_s = 1'b1;
          6'h1A: begin md_s = 1'b1; md_div_s = 1'b1; end
          6'h10: begin mf_s = 1'b1; reg_write_s = 1'b1; reg_dest_s = 1'b1; result_src_s = 2'b01; end
          6'h12: begin mf_s = 1'b1; reg_write_s = 1'b1; reg_dest_s = 1'b1; result_src_s = 2'b10; end
          default: reg_write_s = 1'b0;
        endcase
      end
      6'h23: begin mem_to_reg_s = 1'b1; alu_src_s = 1'b1; reg_write_s = 1'b1; alu_ctrl_s = 3'b010; end
      6'h2B: begin dmem_write_s = 1'b1; alu_src_s = 1'b1; alu_ctrl_s = 3'b010; end
      6'h04: begin branch_s = 1'b1; alu_ctrl_s = 3'b110; end
      6'h08: begin alu_src_s = 1'b1; reg_write_s = 1'b1; alu_ctrl_s = 3'b010; end
      6'h02: jump_s = 1'b1;
      default: reg_write_s = 1'b0;
    endcase
  end

  assign busy_s = (md_cnt_r != CNT_ZERO);

  // Hazard detection: forwarding selects and the ORed stall sources
  always_comb begin
    fwd_a_x_s  = 2'b00;
    fwd_b_x_s  = 2'b00;
    fwd_a_d_s  = 1'b0;
    fwd_b_d_s  = 1'b0;
    fwd_w_m_s  = 1'b0;
    nf_stall_s = 1'b0;
    lu_stall_s = mem_to_reg_x_r &
                 (reg_hit(bus.rs_d, bus.write_reg_x) | reg_hit(bus.rt_d, bus.write_reg_x));
    // A branch resolves in D, so it needs its operands one stage earlier than X does
    br_stall_s = branch_s &
                 ((reg_write_x_r &
                   (reg_hit(bus.rs_d, bus.write_reg_x) | reg_hit(bus.rt_d, bus.write_reg_x))) |
                  (mem_to_reg_m_r &
                   (reg_hit(bus.rs_d, bus.write_reg_m) | reg_hit(bus.rt_d, bus.write_reg_m))));
    md_stall_s = (md_s | mf_s) & (busy_s | md_x_r);
    if (FWD_EN) begin
      if (reg_write_m_r && reg_hit(bus.rs_x, bus.write_reg_m)) begin
        fwd_a_x_s = 2'b10;
      end else if (reg_write_w_r && reg_hit(bus.rs_x, bus.write_reg_w)) begin
        fwd_a_x_s = 2'b01;
      end else begin
        fwd_a_x_s = 2'b00;
      end
      if (reg_write_m_r && reg_hit(bus.rt_x, bus.write_reg_m)) begin
        fwd_b_x_s = 2'b10;
      end else if (reg_write_w_r && reg_hit(bus.rt_x, bus.write_reg_w)) begin
        fwd_b_x_s = 2'b01;
      end else begin
        fwd_b_x_s = 2'b00;
      end
      fwd_a_d_s = reg_write_m_r & reg_hit(bus.rs_d, bus.write_reg_m);
      fwd_b_d_s = reg_write_m_r & reg_hit(bus.rt_d, bus.write_reg_m);
      fwd_w_m_s = dmem_write_m_r & reg_write_w_r & reg_hit(bus.rt_m, bus.write_reg_w);
    end else begin
      // Without bypass paths, hold D until every in-flight producer reaches W
      nf_stall_s = (reg_write_x_r &
                    (reg_hit(bus.rs_d, bus.write_reg_x) | reg_hit(bus.rt_d, bus.write_reg_x))) |
                   (reg_write_m_r &
                    (reg_hit(bus.rs_d, bus.write_reg_m) | reg_hit(bus.rt_d, bus.write_reg_m)));
    end
  end

  assign stall_s  = lu_stall_s | br_stall_s | md_stall_s | nf_stall_s;
  assign pc_src_s = branch_s & bus.eq_d & ~stall_s;
  assign flush_d_s = DELAY_SLOT ? 1'b0 : ((pc_src_s | jump_s) & ~stall_s);

  // D-X register; a stall inserts an all-zero bubble into X
  always_ff @(posedge clk) begin
    if (reset || stall_s) begin
      reg_write_x_r  <= 1'b0;
      mem_to_reg_x_r <= 1'b0;
      dmem_write_x_r <= 1'b0;
      alu_src_x_r    <= 1'b0;
      reg_dest_x_r   <= 1'b0;
      md_x_r         <= 1'b0;
      md_div_x_r     <= 1'b0;
      alu_ctrl_x_r   <= 3'b000;
      result_src_x_r <= 2'b00;
    end else begin
      reg_write_x_r  <= reg_write_s;
      mem_to_reg_x_r <= mem_to_reg_s;
      dmem_write_x_r <= dmem_write_s;
      alu_src_x_r    <= alu_src_s;
      reg_dest_x_r   <= reg_dest_s;
      md_x_r         <= md_s;
      md_div_x_r     <= md_div_s;
      alu_ctrl_x_r   <= alu_ctrl_s;
      result_src_x_r <= result_src_s;
    end
  end

  // X-M and M-W control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m_r  <= 1'b0;
      mem_to_reg_m_r <= 1'b0;
      dmem_write_m_r <= 1'b0;
      reg_write_w_r  <= 1'b0;
      mem_to_reg_w_r <= 1'b0;
    end else begin
      reg_write_m_r  <= reg_write_x_r;
      mem_to_reg_m_r <= mem_to_reg_x_r;
      dmem_write_m_r <= dmem_write_x_r;
      reg_write_w_r  <= reg_write_m_r;
      mem_to_reg_w_r <= mem_to_reg_m_r;
    end
  end

  // Mult/div busy counter; a new issue reloads even if still counting
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_r <= CNT_ZERO;
    end else if (md_x_r) begin
      md_cnt_r <= MD_LOAD;
    end else if (busy_s) begin
      md_cnt_r <= md_cnt_r - CNT_ONE;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  assign bus.mem_to_reg_w = mem_to_reg_w_r;
  assign bus.dmem_write_m = dmem_write_m_r;
  assign bus.reg_write_w  = reg_write_w_r;
  assign bus.alu_src_x    = alu_src_x_r;
  assign bus.reg_dest_x   = reg_dest_x_r;
  assign bus.alu_ctrl_x   = alu_ctrl_x_r;
  assign bus.result_src_x = result_src_x_r;
  assign bus.md_start_x   = md_x_r;
  assign bus.md_div_x     = md_div_x_r;
  assign bus.md_busy      = busy_s;
  assign bus.pc_src_d     = pc_src_s;
  assign bus.jump_d       = jump_s;
  assign bus.stall_f      = stall_s;
  assign bus.stall_d      = stall_s;
  assign bus.flush_x      = stall_s;
  assign bus.flush_d      = flush_d_s;
  assign bus.fwd_a_x      = fwd_a_x_s;
  assign bus.fwd_b_x      = fwd_b_x_s;
  assign bus.fwd_a_d      = fwd_a_d_s;
  assign bus.fwd_b_d      = fwd_b_d_s;
  assign bus.forward_w_m  = fwd_w_m_s;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed-vector bench. A small specifier pipeline
// model (D/X/M/W) feeds the register fields; expected stalls are written by
// hand into each step.
module tb_pipeline_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
  } ins_t;

  localparam ins_t NOP = '0;

  ins_t d_i, x_i, m_i, w_i;
  logic eq_v;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_controller_if #(.REG_W(5)) bus ();
  pipeline_controller_if #(.REG_W(5)) bus_nf ();

  pipeline_controller #(.REG_W(5), .MD_LATENCY(4), .FWD_EN(1'b1), .DELAY_SLOT(1'b0))
    dut (.clk(clk), .reset(reset), .bus(bus));
  pipeline_controller #(.REG_W(5), .MD_LATENCY(4), .FWD_EN(1'b0), .DELAY_SLOT(1'b1))
    dut_nf (.clk(clk), .reset(reset), .bus(bus_nf));

  assign bus.op = d_i.op;           assign bus_nf.op = d_i.op;
  assign bus.funct = d_i.funct;     assign bus_nf.funct = d_i.funct;
  assign bus.eq_d = eq_v;           assign bus_nf.eq_d = eq_v;
  assign bus.rs_d = d_i.rs;         assign bus_nf.rs_d = d_i.rs;
  assign bus.rt_d = d_i.rt;         assign bus_nf.rt_d = d_i.rt;
  assign bus.rs_x = x_i.rs;         assign bus_nf.rs_x = x_i.rs;
  assign bus.rt_x = x_i.rt;         assign bus_nf.rt_x = x_i.rt;
  assign bus.rt_m = m_i.rt;         assign bus_nf.rt_m = m_i.rt;
  assign bus.write_reg_x = x_i.wr;  assign bus_nf.write_reg_x = x_i.wr;
  assign bus.write_reg_m = m_i.wr;  assign bus_nf.write_reg_m = m_i.wr;
  assign bus.write_reg_w = w_i.wr;  assign bus_nf.write_reg_w = w_i.wr;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rt);
    ins_t i;
    i.op = 6'h00; i.funct = fn; i.rs = rs; i.rt = rt; i.wr = rd;
    return i;
  endfunction

  function automatic ins_t i_ins(input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] wr);
    ins_t i;
    i.op = op; i.funct = 6'h00; i.rs = rs; i.rt = rt; i.wr = wr;
    return i;
  endfunction

  // Advance one clock; hold models a D stall (bubble into X, D kept)
  task automatic tick(input logic hold, input ins_t nxt);
    @(posedge clk);
    #1;
    w_i = m_i;
    m_i = x_i;
    if (hold) begin
      x_i = NOP;
    end else begin
      x_i = d_i;
      d_i = nxt;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_i = NOP; x_i = NOP; m_i = NOP; w_i = NOP; eq_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_mem_to_reg_w", bus.mem_to_reg_w, 0);
    check("rst_reg_write_w", bus.reg_write_w, 0);
    check("rst_alu_ctrl_x", bus.alu_ctrl_x, 0);
    check("rst_md_busy", bus.md_busy, 0);
    check("rst_stall", bus.stall_d, 0);

    // Forwarding: add $3,$1,$2 ; sub $4,$3,$3 ; or $5,$3,$0
    d_i = r_ins(6'h20, 5'd3, 5'd1, 5'd2);
    #1;
    check("fw_add_d_stall", bus.stall_d, 0);
    tick(1'b0, r_ins(6'h22, 5'd4, 5'd3, 5'd3));
    check("fw_add_x_alu", bus.alu_ctrl_x, 3'b010);
    check("fw_add_x_regdst", bus.reg_dest_x, 1);
    check("fw_sub_d_stall", bus.stall_f, 0);
    tick(1'b0, r_ins(6'h25, 5'd5, 5'd3, 5'd0));
    check("fw_sub_fwd_a", bus.fwd_a_x, 2'b10);
    check("fw_sub_fwd_b", bus.fwd_b_x, 2'b10);
    check("fw_sub_alu", bus.alu_ctrl_x, 3'b110);
    check("fw_sub_stall", bus.stall_d, 0);
    tick(1'b0, r_ins(6'h20, 5'd0, 5'd1, 5'd2));
    check("fw_or_fwd_a", bus.fwd_a_x, 2'b01);
    check("fw_or_fwd_b_r0", bus.fwd_b_x, 2'b00);
    check("fw_or_alu", bus.alu_ctrl_x, 3'b001);
    check("fw_add_w_regwr", bus.reg_write_w, 1);
    // add $0 followed by a $0 reader: no forward from register zero
    tick(1'b0, r_ins(6'h25, 5'd5, 5'd0, 5'd0));
    tick(1'b0, NOP);
    check("r0_fwd_a", bus.fwd_a_x, 2'b00);

    // Load-use: lw $5,0($1) ; add $6,$5,$2
    tick(1'b0, i_ins(6'h23, 5'd1, 5'd5, 5'd5));
    tick(1'b0, r_ins(6'h20, 5'd6, 5'd5, 5'd2));
    check("lu_stall_f", bus.stall_f, 1);
    check("lu_stall_d", bus.stall_d, 1);
    check("lu_flush_x", bus.flush_x, 1);
    check("lu_lw_alu_src", bus.alu_src_x, 1);
    tick(1'b1, NOP);
    check("lu_stall_end", bus.stall_d, 0);
    check("lu_bubble_alu_src", bus.alu_src_x, 0);
    tick(1'b0, NOP);
    check("lu_fwd_a", bus.fwd_a_x, 2'b01);
    check("lu_mem_to_reg_w", bus.mem_to_reg_w, 1);

    // Branch after load: lw $5 ; beq $5,$0 (taken)
    tick(1'b0, i_ins(6'h23, 5'd1, 5'd5, 5'd5));
    eq_v = 1'b1;
    tick(1'b0, i_ins(6'h04, 5'd5, 5'd0, 5'd0));
    check("br_stall1", bus.stall_d, 1);
    check("br_stall1_pc_src", bus.pc_src_d, 0);
    check("br_stall1_flush_d", bus.flush_d, 0);
    tick(1'b1, NOP);
    check("br_stall2", bus.stall_d, 1);
    check("br_stall2_pc_src", bus.pc_src_d, 0);
    tick(1'b1, NOP);
    check("br_go_stall", bus.stall_d, 0);
    check("br_go_pc_src", bus.pc_src_d, 1);
    check("br_go_flush_d", bus.flush_d, 1);
    eq_v = 1'b0;
    tick(1'b0, NOP);
    check("br_after_flush_d", bus.flush_d, 0);

    // Branch operand forwarded from M: add $7 ; beq $7,$7 (not taken)
    tick(1'b0, r_ins(6'h20, 5'd7, 5'd1, 5'd2));
    tick(1'b0, i_ins(6'h04, 5'd7, 5'd7, 5'd0));
    check("bd_stall", bus.stall_d, 1);
    tick(1'b1, NOP);
    check("bd_stall_end", bus.stall_d, 0);
    check("bd_fwd_a_d", bus.fwd_a_d, 1);
    check("bd_fwd_b_d", bus.fwd_b_d, 1);
    check("bd_pc_src", bus.pc_src_d, 0);

    // Jump without delay slot flushes the following instruction
    tick(1'b0, i_ins(6'h02, 5'd0, 5'd0, 5'd0));
    check("j_jump_d", bus.jump_d, 1);
    check("j_flush_d", bus.flush_d, 1);

    // Store data forward: add $8 ; sw $8,0($1)
    tick(1'b0, r_ins(6'h20, 5'd8, 5'd1, 5'd2));
    tick(1'b0, i_ins(6'h2B, 5'd1, 5'd8, 5'd0));
    check("sw_stall", bus.stall_d, 0);
    tick(1'b0, NOP);
    check("sw_fwd_b_x", bus.fwd_b_x, 2'b10);
    tick(1'b0, NOP);
    check("sw_fwd_w_m", bus.forward_w_m, 1);
    check("sw_dmem_write_m", bus.dmem_write_m, 1);

    // Mult then dependent mfhi
    tick(1'b0, r_ins(6'h18, 5'd0, 5'd1, 5'd2));
    check("md_mult_d_stall", bus.stall_d, 0);
    tick(1'b0, r_ins(6'h10, 5'd9, 5'd0, 5'd0));
    check("md_start", bus.md_start_x, 1);
    check("md_div", bus.md_div_x, 0);
    check("md_busy_t", bus.md_busy, 0);
    check("md_stall_t", bus.stall_d, 1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, NOP);
      check("md_busy_run", bus.md_busy, 1);
      check("md_stall_run", bus.stall_d, 1);
      check("md_start_once", bus.md_start_x, 0);
    end
    tick(1'b1, NOP);
    check("md_busy_done", bus.md_busy, 0);
    check("md_stall_done", bus.stall_d, 0);
    tick(1'b0, NOP);
    check("md_mfhi_result_src", bus.result_src_x, 2'b01);
    check("md_mfhi_regdst", bus.reg_dest_x, 1);

    // Reset mid-operation: mult busy and lw in M
    tick(1'b0, r_ins(6'h18, 5'd0, 5'd1, 5'd2));
    tick(1'b0, i_ins(6'h23, 5'd1, 5'd10, 5'd10));
    tick(1'b0, NOP);
    tick(1'b0, NOP);
    check("mr_busy_before", bus.md_busy, 1);
    reset = 1'b1;
    d_i = NOP; x_i = NOP; m_i = NOP; w_i = NOP;
    @(posedge clk);
    #2;
    check("mr_busy", bus.md_busy, 0);
    check("mr_mem_to_reg_w", bus.mem_to_reg_w, 0);
    check("mr_reg_write_w", bus.reg_write_w, 0);
    check("mr_stall", bus.stall_d, 0);
    reset = 1'b0;

    // No-forward mode: add $3 ; sub $4,$3,$3 on the FWD_EN=0 instance
    do_reset();
    d_i = r_ins(6'h20, 5'd3, 5'd1, 5'd2);
    #1;
    tick(1'b0, r_ins(6'h22, 5'd4, 5'd3, 5'd3));
    check("nf_stall1", bus_nf.stall_d, 1);
    check("nf_fwd_b_x", bus_nf.fwd_b_x, 0);
    tick(1'b1, NOP);
    check("nf_stall2", bus_nf.stall_d, 1);
    check("nf_fwd_a_d", bus_nf.fwd_a_d, 0);
    check("nf_fwd_b_d", bus_nf.fwd_b_d, 0);
    tick(1'b1, NOP);
    check("nf_stall_end", bus_nf.stall_d, 0);
    check("nf_fwd_a_x", bus_nf.fwd_a_x, 0);
    // Delay-slot mode: taken branch never flushes D
    eq_v = 1'b1;
    tick(1'b0, i_ins(6'h04, 5'd0, 5'd0, 5'd0));
    check("ds_pc_src", bus_nf.pc_src_d, 1);
    check("ds_flush_d", bus_nf.flush_d, 0);
    eq_v = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
